// File: rtl/elink_rx_word_aligner.sv
// Receive-path word aligner for a 2-bit-per-cycle elink: finds the K28.5 comma at
// either bit parity, verifies it, and emits aligned 10-bit characters while locked.
module elink_rx_word_aligner #(
    parameter int LOCK_COUNT     = 4,
    parameter int UNLOCK_COUNT   = 8,
    parameter int VERIFY_TIMEOUT = 16
) (
    input  logic       clk_rx,
    input  logic       reset,
    input  logic [1:0] rx_elink2bit,
    output logic [9:0] rx_word,
    output logic       rx_word_valid,
    output logic       rx_is_comma,
    output logic       locked,
    output logic       align_offset,
    output logic       realign_pulse
);
    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;
    localparam logic [3:0] C_LOCK    = 4'(LOCK_COUNT);
    localparam logic [3:0] C_UNLOCK  = 4'(UNLOCK_COUNT);
    localparam logic [5:0] C_TMO     = 6'(VERIFY_TIMEOUT);

    // The lowest shift-register bit never feeds either window, so only [11:1] is kept.
    logic [11:1] r_sr;
    logic [11:1] r_sr_d;
    state_t      r_state;
    logic [2:0]  r_phase;
    logic [3:0]  r_comma_cnt;
    logic [5:0]  r_timeout;
    logic [3:0]  r_err_cnt;
    logic        r_offset;
    logic [9:0]  r_word;
    logic        r_valid;
    logic        r_is_comma;
    logic        r_realign;

    state_t      w_state_nxt;
    logic [2:0]  w_phase_nxt;
    logic [3:0]  w_comma_nxt;
    logic [5:0]  w_timeout_nxt;
    logic [3:0]  w_err_nxt;
    logic        w_offset_nxt;
    logic [9:0]  w_word_nxt;
    logic        w_valid_nxt;
    logic        w_is_comma_nxt;
    logic        w_realign_nxt;
    logic        w_unlock;

    logic [9:0]  w_win_a, w_win_b, w_win_al;
    logic        w_match_a, w_match_b, w_match_any, w_match_al, w_boundary;
    logic [3:0]  w_comma_inc, w_err_inc;
    logic [5:0]  w_timeout_inc;

    // Windows are taken from a one-cycle-delayed copy so a word leaves two edges after its last bits.
    assign w_win_a     = r_sr_d[11:2];
    assign w_win_b     = r_sr_d[10:1];
    assign w_match_a   = (w_win_a == K28_5_RDN) || (w_win_a == K28_5_RDP);
    assign w_match_b   = (w_win_b == K28_5_RDN) || (w_win_b == K28_5_RDP);
    assign w_match_any = w_match_a || w_match_b;
    assign w_win_al    = r_offset ? w_win_b : w_win_a;
    assign w_match_al  = r_offset ? w_match_b : w_match_a;
    assign w_boundary  = (r_phase == 3'd4);

    assign w_comma_inc   = (r_comma_cnt == 4'hF) ? r_comma_cnt : r_comma_cnt + 4'd1;
    assign w_err_inc     = (r_err_cnt == 4'hF) ? r_err_cnt : r_err_cnt + 4'd1;
    assign w_timeout_inc = (r_timeout == 6'h3F) ? r_timeout : r_timeout + 6'd1;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_phase_nxt    = w_boundary ? 3'd0 : r_phase + 3'd1;
        w_comma_nxt    = r_comma_cnt;
        w_timeout_nxt  = r_timeout;
        w_err_nxt      = r_err_cnt;
        w_offset_nxt   = r_offset;
        w_word_nxt     = r_word;
        w_valid_nxt    = 1'b0;
        w_is_comma_nxt = r_is_comma;
        w_realign_nxt  = 1'b0;
        w_unlock       = 1'b0;

        case (r_state)
            S_HUNT: begin
                if (w_match_any) begin
                    w_state_nxt   = S_VERIFY;
                    w_offset_nxt  = !w_match_a;
                    w_phase_nxt   = 3'd0;
                    w_comma_nxt   = 4'd1;
                    w_timeout_nxt = 6'd0;
                    w_err_nxt     = 4'd0;
                end
            end
            S_VERIFY: begin
                if (w_boundary && w_match_al) begin
                    w_timeout_nxt = 6'd0;
                    if (w_comma_inc == C_LOCK) begin
                        w_state_nxt = S_LOCKED;
                        w_comma_nxt = 4'd0;
                        w_err_nxt   = 4'd0;
                    end else begin
                        w_comma_nxt = w_comma_inc;
                    end
                end else if (w_match_any) begin
                    // Comma off the expected boundary: restart verification on it.
                    w_offset_nxt  = !w_match_a;
                    w_phase_nxt   = 3'd0;
                    w_comma_nxt   = 4'd1;
                    w_timeout_nxt = 6'd0;
                end else if (w_boundary) begin
                    if (w_timeout_inc == C_TMO) begin
                        w_state_nxt   = S_HUNT;
                        w_phase_nxt   = 3'd0;
                        w_comma_nxt   = 4'd0;
                        w_timeout_nxt = 6'd0;
                        w_err_nxt     = 4'd0;
                    end else begin
                        w_timeout_nxt = w_timeout_inc;
                    end
                end
            end
            S_LOCKED: begin
                if (w_boundary && w_match_al) begin
                    w_err_nxt = 4'd0;
                end else if (w_match_any) begin
                    if (w_err_inc == C_UNLOCK) begin
                        w_unlock      = 1'b1;
                        w_state_nxt   = S_HUNT;
                        w_realign_nxt = 1'b1;
                        w_phase_nxt   = 3'd0;
                        w_comma_nxt   = 4'd0;
                        w_timeout_nxt = 6'd0;
                        w_err_nxt     = 4'd0;
                    end else begin
                        w_err_nxt = w_err_inc;
                    end
                end
                if (w_boundary && !w_unlock) begin
                    w_valid_nxt    = 1'b1;
                    w_word_nxt     = w_win_al;
                    w_is_comma_nxt = w_match_al;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            r_sr        <= '0;
            r_sr_d      <= '0;
            r_state     <= S_HUNT;
            r_phase     <= '0;
            r_comma_cnt <= '0;
            r_timeout   <= '0;
            r_err_cnt   <= '0;
            r_offset    <= 1'b0;
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_is_comma  <= 1'b0;
            r_realign   <= 1'b0;
        end else begin
            r_sr        <= {rx_elink2bit[1], rx_elink2bit[0], r_sr[11:3]};
            r_sr_d      <= r_sr;
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_comma_cnt <= w_comma_nxt;
            r_timeout   <= w_timeout_nxt;
            r_err_cnt   <= w_err_nxt;
            r_offset    <= w_offset_nxt;
            r_word      <= w_word_nxt;
            r_valid     <= w_valid_nxt;
            r_is_comma  <= w_is_comma_nxt;
            r_realign   <= w_realign_nxt;
        end
    end

    assign rx_word       = r_word;
    assign rx_word_valid = r_valid;
    assign rx_is_comma   = r_is_comma;
    assign locked        = (r_state == S_LOCKED);
    assign align_offset  = r_offset;
    assign realign_pulse = r_realign;

endmodule

// File: tb/tb_elink_rx_word_aligner.sv
// Directed bench for elink_rx_word_aligner: bit streams are built per scenario, outputs are
// logged each cycle on the falling edge, and logs are compared against hand-derived cycle numbers.
module tb_elink_rx_word_aligner;
    localparam int MAXC = 128;

    logic       clk_rx = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] rx_elink2bit = 2'b00;
    logic [9:0] rx_word;
    logic       rx_word_valid, rx_is_comma, locked, align_offset, realign_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] word_log   [MAXC];
    logic       valid_log  [MAXC];
    logic       comma_log  [MAXC];
    logic       locked_log [MAXC];
    logic       off_log    [MAXC];
    logic       pulse_log  [MAXC];
    logic       bits [$];

    always #5 clk_rx = ~clk_rx;

    elink_rx_word_aligner dut (
        .clk_rx        (clk_rx),
        .reset         (reset),
        .rx_elink2bit  (rx_elink2bit),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .rx_is_comma   (rx_is_comma),
        .locked        (locked),
        .align_offset  (align_offset),
        .realign_pulse (realign_pulse)
    );

    task automatic push_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) bits.push_back(w[i]);
    endtask

    task automatic push_bit(input logic b);
        bits.push_back(b);
    endtask

    // Index c of every log holds the outputs produced by the edge that sampled pair c.
    task automatic run_stream(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            logic b0, b1;
            b0 = (2 * c < bits.size()) ? bits[2 * c] : 1'b0;
            b1 = (2 * c + 1 < bits.size()) ? bits[2 * c + 1] : 1'b0;
            rx_elink2bit = {b1, b0};
            @(negedge clk_rx);
            word_log[c]   = rx_word;
            valid_log[c]  = rx_word_valid;
            comma_log[c]  = rx_is_comma;
            locked_log[c] = locked;
            off_log[c]    = align_offset;
            pulse_log[c]  = realign_pulse;
        end
        rx_elink2bit = 2'b00;
        bits.delete();
    endtask

    task automatic do_reset();
        rx_elink2bit = 2'b00;
        reset = 1'b1;
        repeat (2) @(negedge clk_rx);
        reset = 1'b0;
    endtask

    function automatic int count_valid(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (valid_log[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_locked(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (locked_log[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_pulse(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (pulse_log[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_valid(input int hi);
        for (int c = 0; c <= hi; c++) if (valid_log[c] === 1'b1) return c;
        return -1;
    endfunction

    // Counts strobes that break the 5-cycle grid from 'first' or carry the wrong word.
    function automatic int bad_strobes(input int first, input int hi, input logic off);
        int n = 0;
        for (int c = 0; c <= hi; c++)
            if (valid_log[c] === 1'b1)
                if (((c - first) % 5 != 0) || (c < first) || (word_log[c] !== 10'h17C) ||
                    (comma_log[c] !== 1'b1) || (off_log[c] !== off)) n++;
        return n;
    endfunction

    task automatic test_reset();
        rx_elink2bit = 2'b11;
        reset = 1'b1;
        repeat (3) @(negedge clk_rx);
        n_tests++;
        if ({rx_word, rx_word_valid, rx_is_comma, locked, align_offset, realign_pulse} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h expected 0", {rx_word, rx_word_valid, rx_is_comma,
                     locked, align_offset, realign_pulse});
        end
        reset = 1'b0;
        run_stream(10);
        n_tests++;
        if ({word_log[9], valid_log[9], comma_log[9], locked_log[9], off_log[9], pulse_log[9]} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h expected 0", {word_log[9], valid_log[9],
                     comma_log[9], locked_log[9], off_log[9], pulse_log[9]});
        end
    endtask

    task automatic test_even_offset();
        int fv, nb;
        do_reset();
        repeat (12) push_word(10'h17C);
        run_stream(60);
        n_tests++;
        if (locked_log[20] !== 1'b0 || locked_log[21] !== 1'b1) begin
            n_fail++;
            $display("FAIL even_lock_edge: locked[20]=%b locked[21]=%b expected 0 1", locked_log[20], locked_log[21]);
        end
        fv = first_valid(59);
        n_tests++;
        if (fv !== 26) begin
            n_fail++;
            $display("FAIL even_first_valid: cycle %0d expected 26", fv);
        end
        n_tests++;
        if (count_valid(0, 59) !== 7) begin
            n_fail++;
            $display("FAIL even_strobe_count: %0d expected 7", count_valid(0, 59));
        end
        nb = bad_strobes(26, 59, 1'b0);
        n_tests++;
        if (nb !== 0) begin
            n_fail++;
            $display("FAIL even_strobe_content: %0d bad strobes expected 0", nb);
        end
    endtask

    task automatic test_odd_offset();
        int fv, nb;
        do_reset();
        push_bit(1'b0);
        repeat (12) push_word(10'h17C);
        run_stream(61);
        n_tests++;
        if (locked_log[21] !== 1'b0 || locked_log[22] !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_lock_edge: locked[21]=%b locked[22]=%b expected 0 1", locked_log[21], locked_log[22]);
        end
        fv = first_valid(60);
        n_tests++;
        if (fv !== 27) begin
            n_fail++;
            $display("FAIL odd_first_valid: cycle %0d expected 27", fv);
        end
        n_tests++;
        if (count_valid(0, 60) !== 7) begin
            n_fail++;
            $display("FAIL odd_strobe_count: %0d expected 7", count_valid(0, 60));
        end
        nb = bad_strobes(27, 60, 1'b1);
        n_tests++;
        if (nb !== 0) begin
            n_fail++;
            $display("FAIL odd_strobe_content: %0d bad strobes expected 0 (offset 1)", nb);
        end
    endtask

    task automatic test_data_words();
        logic [9:0] pattern [3];
        pattern[0] = 10'h17C;
        pattern[1] = 10'h283;
        pattern[2] = 10'h2AA;
        do_reset();
        repeat (4) push_word(10'h17C);
        for (int t = 0; t < 9; t++) push_word(pattern[t % 3]);
        run_stream(70);
        for (int j = 4; j <= 12; j++) begin
            int c;
            logic [9:0] exp_w;
            logic exp_k;
            c = 5 * j + 6;
            exp_w = pattern[(j - 4) % 3];
            exp_k = (exp_w != 10'h2AA);
            n_tests++;
            if (valid_log[c] !== 1'b1 || word_log[c] !== exp_w || comma_log[c] !== exp_k) begin
                n_fail++;
                $display("FAIL data_word_%0d: valid=%b word=%h comma=%b expected 1 %h %b",
                         j, valid_log[c], word_log[c], comma_log[c], exp_w, exp_k);
            end
        end
        n_tests++;
        if (count_valid(0, 69) !== 9) begin
            n_fail++;
            $display("FAIL data_strobe_count: %0d expected 9", count_valid(0, 69));
        end
        n_tests++;
        if (count_locked(21, 69) !== 49) begin
            n_fail++;
            $display("FAIL data_locked_held: %0d locked cycles expected 49", count_locked(21, 69));
        end
        n_tests++;
        if (valid_log[33] !== 1'b0 || word_log[33] !== 10'h283) begin
            n_fail++;
            $display("FAIL data_word_hold: valid=%b word=%h expected 0 283", valid_log[33], word_log[33]);
        end
    endtask

    task automatic test_slip_realign();
        do_reset();
        repeat (6) push_word(10'h17C);
        push_bit(1'b0);
        repeat (13) push_word(10'h17C);
        run_stream(100);
        n_tests++;
        if (locked_log[71] !== 1'b1 || locked_log[72] !== 1'b0) begin
            n_fail++;
            $display("FAIL slip_unlock_edge: locked[71]=%b locked[72]=%b expected 1 0", locked_log[71], locked_log[72]);
        end
        n_tests++;
        if (pulse_log[72] !== 1'b1 || count_pulse(0, 99) !== 1) begin
            n_fail++;
            $display("FAIL slip_realign_pulse: pulse[72]=%b total=%0d expected 1 1", pulse_log[72], count_pulse(0, 99));
        end
        n_tests++;
        if (count_valid(72, 96) !== 0) begin
            n_fail++;
            $display("FAIL slip_no_words_unlocked: %0d strobes expected 0", count_valid(72, 96));
        end
        n_tests++;
        if (locked_log[91] !== 1'b0 || locked_log[92] !== 1'b1 || off_log[92] !== 1'b1) begin
            n_fail++;
            $display("FAIL slip_relock: locked[91]=%b locked[92]=%b offset=%b expected 0 1 1",
                     locked_log[91], locked_log[92], off_log[92]);
        end
        n_tests++;
        if (valid_log[97] !== 1'b1 || word_log[97] !== 10'h17C || comma_log[97] !== 1'b1) begin
            n_fail++;
            $display("FAIL slip_first_word: valid=%b word=%h comma=%b expected 1 17c 1",
                     valid_log[97], word_log[97], comma_log[97]);
        end
    endtask

    task automatic test_verify_timeout();
        // Sixteen data words time VERIFY out, so four fresh commas are needed to lock.
        do_reset();
        push_word(10'h17C);
        repeat (16) push_word(10'h2AA);
        repeat (4) push_word(10'h17C);
        run_stream(110);
        n_tests++;
        if (count_locked(0, 105) !== 0 || locked_log[106] !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout16_relock: early locked cycles=%0d locked[106]=%b expected 0 1",
                     count_locked(0, 105), locked_log[106]);
        end
        // Fifteen data words stay inside the window, so the running count continues.
        do_reset();
        push_word(10'h17C);
        repeat (15) push_word(10'h2AA);
        repeat (4) push_word(10'h17C);
        run_stream(110);
        n_tests++;
        if (locked_log[95] !== 1'b0 || locked_log[96] !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout15_continue: locked[95]=%b locked[96]=%b expected 0 1", locked_log[95], locked_log[96]);
        end
    endtask

    task automatic test_zero_stream();
        do_reset();
        run_stream(80);
        n_tests++;
        if (count_locked(0, 79) !== 0 || count_valid(0, 79) !== 0) begin
            n_fail++;
            $display("FAIL zero_stream: locked cycles=%0d strobes=%0d expected 0 0",
                     count_locked(0, 79), count_valid(0, 79));
        end
    endtask

    task automatic test_reset_while_locked();
        do_reset();
        repeat (8) push_word(10'h17C);
        run_stream(35);
        n_tests++;
        if (locked_log[34] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_prelock: locked=%b expected 1", locked_log[34]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({rx_word, rx_word_valid, rx_is_comma, locked, align_offset, realign_pulse} !== 15'h0) begin
            n_fail++;
            $display("FAIL midreset_async_clear: outputs=%h expected 0", {rx_word, rx_word_valid,
                     rx_is_comma, locked, align_offset, realign_pulse});
        end
        repeat (2) @(negedge clk_rx);
        reset = 1'b0;
        repeat (6) push_word(10'h17C);
        run_stream(30);
        n_tests++;
        if (locked_log[20] !== 1'b0 || locked_log[21] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_relock: locked[20]=%b locked[21]=%b expected 0 1", locked_log[20], locked_log[21]);
        end
        n_tests++;
        if (valid_log[26] !== 1'b1 || word_log[26] !== 10'h17C) begin
            n_fail++;
            $display("FAIL midreset_first_word: valid=%b word=%h expected 1 17c", valid_log[26], word_log[26]);
        end
    endtask

    initial begin
        test_reset();
        test_even_offset();
        test_odd_offset();
        test_data_words();
        test_slip_realign();
        test_verify_timeout();
        test_zero_stream();
        test_reset_while_locked();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
